// File: rtl/snn_result_sender.sv
// Result-return transmitter: start, then per timestep ts/layer/spike pairs read from result memory, then done.
// Optional per-timestep data checksum enabled by defining SNN_RESULT_CHECKSUM_EN.
module snn_result_sender #(
    parameter int WIDTH_ADDR     = 12,
    parameter int WIDTH_OUT_DATA = 13,
    parameter int DEPTH_R        = 21,
    parameter int NUM_TS         = 2,
    parameter int LAYER_IDX      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go,
    output logic                        busy,
    output logic                        mem_rd_en,
    output logic [1:0]                  mem_rd_ts,
    output logic [WIDTH_ADDR-1:0]       mem_rd_addr,
    input  logic [WIDTH_OUT_DATA-1:0]   mem_rd_data,
    output logic                        start_r_valid,
    output logic                        start_r_data,
    input  logic                        start_r_ready,
    output logic                        ts_r_valid,
    output logic [1:0]                  ts_r_data,
    input  logic                        ts_r_ready,
    output logic                        layer_r_valid,
    output logic [1:0]                  layer_r_data,
    input  logic                        layer_r_ready,
    output logic                        out_spike_addr_valid,
    output logic [WIDTH_ADDR-1:0]       out_spike_addr_data,
    input  logic                        out_spike_addr_ready,
    output logic                        out_spike_data_valid,
    output logic [WIDTH_OUT_DATA-1:0]   out_spike_data_data,
    input  logic                        out_spike_data_ready,
    output logic                        done_r_valid,
    output logic                        done_r_data,
    input  logic                        done_r_ready,
    output logic [WIDTH_OUT_DATA+8:0]   ts_checksum,
    output logic                        ts_checksum_valid
);

    localparam logic [WIDTH_ADDR-1:0] LAST_I = WIDTH_ADDR'(DEPTH_R * DEPTH_R - 1);
    localparam logic [1:0]            LAST_T = 2'(NUM_TS);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TS, S_LAYER, S_RD, S_ADDR, S_DATA, S_DONE
    } state_t;

    state_t                    state, next_state;
    logic [WIDTH_ADDR-1:0]     idx;
    logic [1:0]                ts;
    logic [WIDTH_OUT_DATA-1:0] data_q;
    logic                      rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // rd_q marks the first ADDR cycle, when the memory's registered read data is valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            ts     <= 2'd1;
            data_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= (state == S_RD);
            if (rd_q) data_q <= mem_rd_data;
            case (state)
                S_START: if (start_r_ready) ts <= 2'd1;
                S_LAYER: if (layer_r_ready) idx <= '0;
                S_DATA: begin
                    if (out_spike_data_ready) begin
                        if (idx < LAST_I)     idx <= idx + 1'b1;
                        else if (ts < LAST_T) ts <= ts + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state           = state;
        busy                 = (state != S_IDLE);
        mem_rd_en            = 1'b0;
        mem_rd_ts            = ts;
        mem_rd_addr          = '0;
        start_r_valid        = 1'b0;
        start_r_data         = 1'b0;
        ts_r_valid           = 1'b0;
        ts_r_data            = '0;
        layer_r_valid        = 1'b0;
        layer_r_data         = '0;
        out_spike_addr_valid = 1'b0;
        out_spike_addr_data  = '0;
        out_spike_data_valid = 1'b0;
        out_spike_data_data  = '0;
        done_r_valid         = 1'b0;
        done_r_data          = 1'b0;
        case (state)
            S_IDLE: if (go) next_state = S_START;
            S_START: begin
                start_r_valid = 1'b1;
                start_r_data  = 1'b1;
                if (start_r_ready) next_state = S_TS;
            end
            S_TS: begin
                ts_r_valid = 1'b1;
                ts_r_data  = ts;
                if (ts_r_ready) next_state = S_LAYER;
            end
            S_LAYER: begin
                layer_r_valid = 1'b1;
                layer_r_data  = 2'(LAYER_IDX);
                if (layer_r_ready) next_state = S_RD;
            end
            S_RD: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = idx;
                next_state  = S_ADDR;
            end
            S_ADDR: begin
                out_spike_addr_valid = 1'b1;
                out_spike_addr_data  = idx;
                if (out_spike_addr_ready) next_state = S_DATA;
            end
            S_DATA: begin
                out_spike_data_valid = 1'b1;
                out_spike_data_data  = data_q;
                if (out_spike_data_ready) begin
                    if (idx < LAST_I)     next_state = S_RD;
                    else if (ts < LAST_T) next_state = S_TS;
                    else                  next_state = S_DONE;
                end
            end
            S_DONE: begin
                done_r_valid = 1'b1;
                done_r_data  = 1'b1;
                if (done_r_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

`ifdef SNN_RESULT_CHECKSUM_EN
    logic [WIDTH_OUT_DATA+8:0] acc;
    logic [WIDTH_OUT_DATA+8:0] acc_next;

    assign acc_next = acc + {9'd0, data_q};

    // Clearing throughout TS is equivalent to clearing on entry: no spike transfers there
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc               <= '0;
            ts_checksum       <= '0;
            ts_checksum_valid <= 1'b0;
        end else begin
            ts_checksum_valid <= 1'b0;
            if (state == S_TS) acc <= '0;
            if (state == S_DATA && out_spike_data_ready) begin
                acc <= acc_next;
                if (idx == LAST_I) begin
                    ts_checksum       <= acc_next;
                    ts_checksum_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign ts_checksum       = '0;
    assign ts_checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_snn_result_sender.sv
// Self-checking bench for snn_result_sender: token stream vs. a list-building reference model,
// latency, backpressure stability, go filtering, mid-stream reset, small configuration, checksum.
module tb_snn_result_sender;

    localparam int WA = 12;
    localparam int WD = 13;
    localparam int DR = 21;
    localparam int NT = 2;
    localparam int NSP = DR * DR;
    localparam int BUDGET = 20000;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] val;
    } tok_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0;
    logic go_s = 1'b0;
    logic [5:0] rdy = '1;
    logic stall_en = 1'b0;
    int   cyc = 0;

    logic          busy, mem_rd_en;
    logic [1:0]    mem_rd_ts;
    logic [WA-1:0] mem_rd_addr;
    logic [WD-1:0] mem_rd_data = '0;
    logic          start_v, start_d, ts_v, layer_v, addr_v, data_v, done_v, done_d;
    logic [1:0]    ts_d, layer_d;
    logic [WA-1:0] addr_d;
    logic [WD-1:0] data_d;
    logic [WD+8:0] chk_sum;
    logic          chk_v;

    logic          busy_s, rd_en_s;
    logic [1:0]    rd_ts_s;
    logic [WA-1:0] rd_addr_s;
    logic [WD-1:0] rd_data_s = '0;
    logic          sv_s, sd_s, tv_s, lv_s, av_s, dv_s, ev_s, ed_s;
    logic [1:0]    td_s, ld_s;
    logic [WA-1:0] ad_s;
    logic [WD-1:0] dd_s;
    logic [WD+8:0] cs_s;
    logic          cv_s;

    logic [WD-1:0] mem [0:3][0:4095];

    tok_t obs[$], obs_s[$], exp_q[$];
    logic [WD+8:0] chk_q[$];
    int   checks = 0, passes = 0, fails = 0;
    int   go_cyc, done_cyc, rd_cnt, stab_viol, multi_viol, chk_nz;
    logic done_seen, done_seen_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_ts][mem_rd_addr];
        if (rd_en_s)   rd_data_s   <= mem[rd_ts_s][rd_addr_s];
    end

    snn_result_sender u_dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_rd_ts(mem_rd_ts), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .start_r_valid(start_v), .start_r_data(start_d), .start_r_ready(rdy[0]),
        .ts_r_valid(ts_v), .ts_r_data(ts_d), .ts_r_ready(rdy[1]),
        .layer_r_valid(layer_v), .layer_r_data(layer_d), .layer_r_ready(rdy[2]),
        .out_spike_addr_valid(addr_v), .out_spike_addr_data(addr_d), .out_spike_addr_ready(rdy[3]),
        .out_spike_data_valid(data_v), .out_spike_data_data(data_d), .out_spike_data_ready(rdy[4]),
        .done_r_valid(done_v), .done_r_data(done_d), .done_r_ready(rdy[5]),
        .ts_checksum(chk_sum), .ts_checksum_valid(chk_v)
    );

    snn_result_sender #(.NUM_TS(1), .DEPTH_R(3)) u_small (
        .clk(clk), .rst_n(rst_n), .go(go_s), .busy(busy_s),
        .mem_rd_en(rd_en_s), .mem_rd_ts(rd_ts_s), .mem_rd_addr(rd_addr_s), .mem_rd_data(rd_data_s),
        .start_r_valid(sv_s), .start_r_data(sd_s), .start_r_ready(1'b1),
        .ts_r_valid(tv_s), .ts_r_data(td_s), .ts_r_ready(1'b1),
        .layer_r_valid(lv_s), .layer_r_data(ld_s), .layer_r_ready(1'b1),
        .out_spike_addr_valid(av_s), .out_spike_addr_data(ad_s), .out_spike_addr_ready(1'b1),
        .out_spike_data_valid(dv_s), .out_spike_data_data(dd_s), .out_spike_data_ready(1'b1),
        .done_r_valid(ev_s), .done_r_data(ed_s), .done_r_ready(1'b1),
        .ts_checksum(cs_s), .ts_checksum_valid(cv_s)
    );

    // Ready driver: each channel low for a random 0..5 cycles between single high cycles
    initial begin
        int cnt[6];
        foreach (cnt[k]) cnt[k] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < 6; ch++) begin
                if (!stall_en) rdy[ch] = 1'b1;
                else if (cnt[ch] > 0) begin rdy[ch] = 1'b0; cnt[ch]--; end
                else begin rdy[ch] = 1'b1; cnt[ch] = $urandom_range(0, 5); end
            end
        end
    end

    // Monitor on the falling edge: a valid&&ready seen here transfers at the next rising edge
    initial begin
        logic [5:0]  v;
        logic [31:0] val [6];
        int          pch;
        logic [31:0] pval;
        pch = -1;
        pval = '0;
        forever begin
            @(negedge clk);
            v = {done_v, data_v, addr_v, layer_v, ts_v, start_v};
            val[0] = 32'(start_d); val[1] = 32'(ts_d); val[2] = 32'(layer_d);
            val[3] = 32'(addr_d);  val[4] = 32'(data_d); val[5] = 32'(done_d);
            if (mem_rd_en) rd_cnt++;
            if ($countones(v) > 1) multi_viol++;
            if (chk_v) chk_q.push_back(chk_sum);
            if (chk_v || chk_sum != '0) chk_nz++;
            if (pch >= 0 && (!v[pch] || val[pch] != pval)) stab_viol++;
            pch = -1;
            for (int ch = 0; ch < 6; ch++) begin
                if (v[ch] && rdy[ch] && rst_n) begin
                    obs.push_back('{ch: 3'(ch), val: val[ch]});
                    if (ch == 5) begin done_seen = 1'b1; done_cyc = cyc; end
                end else if (v[ch] && rst_n) begin
                    pch = ch; pval = val[ch];
                end
            end
            if (sv_s) obs_s.push_back('{ch: 3'd0, val: 32'(sd_s)});
            if (tv_s) obs_s.push_back('{ch: 3'd1, val: 32'(td_s)});
            if (lv_s) obs_s.push_back('{ch: 3'd2, val: 32'(ld_s)});
            if (av_s) obs_s.push_back('{ch: 3'd3, val: 32'(ad_s)});
            if (dv_s) obs_s.push_back('{ch: 3'd4, val: 32'(dd_s)});
            if (ev_s) begin obs_s.push_back('{ch: 3'd5, val: 32'(ed_s)}); done_seen_s = 1'b1; end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Reference stream built directly from the protocol description
    task automatic build_exp(input int nts, input int depth);
        exp_q.delete();
        exp_q.push_back('{ch: 3'd0, val: 32'd1});
        for (int t = 1; t <= nts; t++) begin
            exp_q.push_back('{ch: 3'd1, val: 32'(t)});
            exp_q.push_back('{ch: 3'd2, val: 32'd1});
            for (int i = 0; i < depth * depth; i++) begin
                exp_q.push_back('{ch: 3'd3, val: 32'(i)});
                exp_q.push_back('{ch: 3'd4, val: 32'(mem[t][i])});
            end
        end
        exp_q.push_back('{ch: 3'd5, val: 32'd1});
    endtask

    task automatic cmp_stream(input string tag, input tok_t q[$]);
        chk({tag, "_len"}, 64'(q.size()), 64'(exp_q.size()));
        for (int k = 0; k < q.size() && k < exp_q.size(); k++)
            chk({tag, "_tok"}, 64'(q[k]), 64'(exp_q[k]));
    endtask

    task automatic fill_mem(input bit rnd);
        for (int t = 1; t <= 2; t++)
            for (int i = 0; i < NSP; i++)
                mem[t][i] = rnd ? WD'($urandom) : WD'(i + 100 * t);
    endtask

    task automatic clear_obs();
        obs.delete(); chk_q.delete();
        done_seen = 1'b0; rd_cnt = 0; stab_viol = 0; multi_viol = 0;
    endtask

    task automatic pulse_go();
        @(posedge clk); #1;
        go = 1'b1; go_cyc = cyc;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done_seen && n < BUDGET) begin @(posedge clk); #2; n++; end
        if (!done_seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
        else begin @(posedge clk); #2; end
    endtask

    task automatic chk_sums(input string tag);
`ifdef SNN_RESULT_CHECKSUM_EN
        logic [WD+8:0] s;
        chk({tag, "_cs_cnt"}, 64'(chk_q.size()), 64'(NT));
        for (int t = 1; t <= NT && t <= chk_q.size(); t++) begin
            s = '0;
            for (int i = 0; i < NSP; i++) s += (WD+9)'(mem[t][i]);
            chk({tag, "_cs_val"}, 64'(chk_q[t-1]), 64'(s));
        end
`else
        chk({tag, "_cs_cnt"}, 64'(chk_q.size()), 64'd0);
`endif
    endtask

    initial begin
        int n;
        chk_nz = 0;
        clear_obs();
        fill_mem(1'b0);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #2;
        chk("rst_valids", 64'({start_v, ts_v, layer_v, addr_v, data_v, done_v}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_rd_ts", 64'(mem_rd_ts), 64'd1);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_data", 64'({start_d, ts_d, layer_d, addr_d, data_d, done_d}), 64'd0);
        chk("rst_cs", 64'({chk_v, chk_sum}), 64'd0);

        // Run 1: readies high, memory[t][i] = i + 100*t
        clear_obs();
        build_exp(NT, DR);
        chk("exp_data_t2_last", 64'(exp_q[exp_q.size()-2].val), 64'd640);
        pulse_go();
        chk("busy_after_go", 64'(busy), 64'd1);
        wait_done("run1");
        cmp_stream("run1", obs);
        chk("run1_latency", 64'(done_cyc - go_cyc), 64'(2 + NT * (2 + 3 * NSP)));
        chk("run1_busy_drop", 64'(busy), 64'd0);
        chk("run1_rd_cnt", 64'(rd_cnt), 64'(NT * NSP));
        chk_sums("run1");

        // Run 2: random stalls on every channel
        clear_obs();
        stall_en = 1'b1;
        pulse_go();
        wait_done("run2");
        cmp_stream("run2", obs);
        chk("run2_rd_cnt", 64'(rd_cnt), 64'(NT * NSP));
        chk("run2_stable", 64'(stab_viol), 64'd0);
        chk("run2_onehot", 64'(multi_viol), 64'd0);
        chk_sums("run2");

        // Run 3: random memory contents under stalls
        fill_mem(1'b1);
        build_exp(NT, DR);
        clear_obs();
        pulse_go();
        wait_done("run3");
        cmp_stream("run3", obs);
        chk("run3_stable", 64'(stab_viol), 64'd0);
        chk_sums("run3");
        stall_en = 1'b0;
        fill_mem(1'b0);
        build_exp(NT, DR);

        // Extra go pulses while busy yield one run
        clear_obs();
        pulse_go();
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(10, 300)) @(posedge clk);
            pulse_go();
        end
        wait_done("run4");
        cmp_stream("run4", obs);
        chk("run4_busy_drop", 64'(busy), 64'd0);
        repeat (20) @(posedge clk);
        #2;
        chk("run4_no_rerun", 64'(obs.size()), 64'(exp_q.size()));
        clear_obs();
        pulse_go();
        wait_done("run5");
        cmp_stream("run5", obs);

        // Mid-stream reset at ADDR with i=200, t=2
        clear_obs();
        pulse_go();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(addr_v && addr_d == WA'(200) && mem_rd_ts == 2'd2) && n < BUDGET);
        chk("rst_mid_reached", 64'(n < BUDGET), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_valids", 64'({start_v, ts_v, layer_v, addr_v, data_v, done_v}), 64'd0);
        chk("rst_mid_idle", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        clear_obs();
        pulse_go();
        wait_done("run6");
        cmp_stream("run6", obs);

        // Small configuration: NUM_TS=1, DEPTH_R=3
        obs_s.delete();
        done_seen_s = 1'b0;
        build_exp(1, 3);
        @(posedge clk); #1 go_s = 1'b1;
        @(posedge clk); #1 go_s = 1'b0;
        n = 0;
        while (!done_seen_s && n < 200) begin @(posedge clk); n++; end
        chk("small_done", 64'(done_seen_s), 64'd1);
        cmp_stream("small", obs_s);

`ifndef SNN_RESULT_CHECKSUM_EN
        chk("cs_always_zero", 64'(chk_nz), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/snn_result_sender.md
Name: snn_result_sender

Overview:
- Clocked transmitter for the result-return protocol: sends start_r, then ts_r, layer_r and DEPTH_R*DEPTH_R (out_spike_addr, out_spike_data) pairs per timestep, then done_r.
- It is the sending end of the stream the control bench receives and checks against out_spike1/out_spike2.
- Sits between the result memory (read port) and the output channels.
- Each channel is one valid/ready word link, with one token per handshake.

Parameters:
WIDTH_ADDR, 12, width of out_spike_addr
WIDTH_OUT_DATA, 13, width of out_spike_data and result-memory data
DEPTH_R, 21, output map side; DEPTH_R*DEPTH_R spikes per timestep
NUM_TS, 2, number of timesteps sent (values 1..NUM_TS)
LAYER_IDX, 1, constant value sent on layer_r

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
go  in  1  one-cycle pulse: all result data is resident in memory
busy  out  1  high from the cycle after an accepted go until done_r transfers
mem_rd_en  out  1  result-memory read strobe
mem_rd_ts  out  2  timestep being read (1..NUM_TS)
mem_rd_addr  out  WIDTH_ADDR  spike index being read
mem_rd_data  in  WIDTH_OUT_DATA  read data, valid 1 cycle after mem_rd_en
start_r_valid/start_r_data/start_r_ready  out/out/in  1/1/1  start token (data=1)
ts_r_valid/ts_r_data/ts_r_ready  out/out/in  1/2/1  timestep token
layer_r_valid/layer_r_data/layer_r_ready  out/out/in  1/2/1  layer token
out_spike_addr_valid/_data/_ready  out/out/in  1/WIDTH_ADDR/1  spike address
out_spike_data_valid/_data/_ready  out/out/in  1/WIDTH_OUT_DATA/1  spike value
done_r_valid/done_r_data/done_r_ready  out/out/in  1/1/1  completion token (data=1)
ts_checksum  out  WIDTH_OUT_DATA+9  per-timestep data sum (optional feature)
ts_checksum_valid  out  1  one-cycle pulse with ts_checksum

Behaviour:
- Reset: synchronous, active-low, single clock domain (clk).
  - Applied when rst_n is low at a rising clk edge.
  - All *_valid, busy, mem_rd_en and ts_checksum_valid are 0.
  - All *_data, mem_rd_addr and ts_checksum are 0; mem_rd_ts = 1.
  - State returns to IDLE and counters clear. This also applies mid-stream; there is no partial resume.
- Handshake: a transfer occurs on the rising edge where valid && ready.
  - Once valid is high, data is held stable and valid stays high until the transfer.
  - ready may be high before valid.
  - Exactly one output valid is high at any time, giving strict sequential order.
- FSM states: IDLE, START, TS, LAYER, RD, ADDR, DATA, DONE.
  - IDLE: go=1 -> START on the next cycle; busy=1.
  - START: start_r_valid=1, data 1. On transfer -> TS, with t=1.
  - TS: ts_r_data=t. On transfer -> LAYER.
  - LAYER: layer_r_data=LAYER_IDX. On transfer -> RD, with i=0.
  - RD: mem_rd_en=1 for exactly one cycle, mem_rd_ts=t, mem_rd_addr=i. -> ADDR.
  - ADDR: mem_rd_data is captured into the data register on the first ADDR cycle. out_spike_addr_data=i. On transfer -> DATA.
  - DATA: out_spike_data_data = captured value.
    - On transfer with i<DEPTH_R^2-1: i++ and go to RD.
    - Otherwise, if t<NUM_TS: t++ and go to TS.
    - Otherwise go to DONE.
  - DONE: done_r_data=1. On transfer -> IDLE; busy=0 on the next cycle.
- go is ignored while busy or in the same cycle as the done_r transfer. go in IDLE is accepted even if held high for several cycles, producing one run per rising acceptance.
- Counters: i is WIDTH_ADDR bits, 0..DEPTH_R^2-1 (440 at default); t is 2 bits.
- Latency with all readies held high:
  - go -> start_r_valid: 1 cycle.
  - Each token: 1 cycle; each spike: 3 cycles.
  - Total per run: 2 + NUM_TS*(2 + 3*DEPTH_R^2) cycles, which is 2652 at defaults.
- Backpressure on any channel stalls only the FSM. The memory is not re-read, and the captured data is held.

Optional Feature:
- Macro: SNN_RESULT_CHECKSUM_EN.
- With the macro defined:
  - A WIDTH_OUT_DATA+9-bit accumulator clears on entry to TS.
  - It adds each out_spike_data value at its transfer.
  - On the last spike transfer of a timestep, ts_checksum is loaded with the final sum and ts_checksum_valid pulses for 1 cycle on the following cycle.
- Without the macro: ts_checksum=0 and ts_checksum_valid=0 constantly, with no accumulator logic.

Test Plan:
- Reset, then go with all readies high and memory[t][i]=i+100*t:
  - Tokens arrive in order: start=1, ts=1, layer=1, addr/data 0..440 with data 100..540, ts=2, layer=1, data 200..640, done=1.
  - done transfers 2652 cycles after go.
- Random ready stalls (0-5 cycles) on every channel:
  - The token sequence is identical to the first test.
  - Data is stable while valid is high, and mem_rd_en pulses exactly 882 times.
- Extra go pulses while busy: exactly one run is produced; busy drops 1 cycle after the done transfer; a second go then starts a new run.
- rst_n low for 1 cycle while at ADDR with i=200, t=2:
  - All valids are 0 on the next cycle, and the state is IDLE.
  - A following go restarts at start_r with ts=1 and addr=0.
- NUM_TS=1, DEPTH_R=3: the sequence is start, ts=1, layer, 9 pairs, done.
- With SNN_RESULT_CHECKSUM_EN and the data of the first test:
  - ts_checksum=141120 (t=1) and 185220 (t=2), each pulsed once.
  - Without the macro, both checksum outputs stay 0.
